// File: rtl/main_ctrl_pkg.sv
// Shared constants for the training controller: mode codes, state codes,
// stage bit positions and a mode legality helper.
package main_ctrl_pkg;

    localparam int MODE_LEN  = 3;
    localparam int STATE_LEN = 4;
    localparam int STAGE_N   = 5;

    localparam logic [MODE_LEN-1:0] FORWARD = 3'b001;
    localparam logic [MODE_LEN-1:0] TRAIN   = 3'b010;

    // Stage bit positions within stage_run / stage_done
    localparam int ST_EMB  = 0;
    localparam int ST_MIX  = 1;
    localparam int ST_COMP = 2;
    localparam int ST_BWD  = 3;
    localparam int ST_UPD  = 4;

    typedef enum logic [STATE_LEN-1:0] {
        IDLE   = 4'd0,
        READY  = 4'd1,
        M_EMB  = 4'd2,
        M_MIX  = 4'd3,
        M_COMP = 4'd4,
        M_BWD  = 4'd5,
        M_UPD  = 4'd6,
        FINISH = 4'd7,
        ERROR  = 4'd8
    } state_t;

    function automatic logic mode_legal(input logic [MODE_LEN-1:0] m);
        return (m == FORWARD) || (m == TRAIN);
    endfunction

endpackage

// File: rtl/main_ctrl_if.sv
// Stage and stream handshake bundle between the controller (master) and the
// datapath stages / stream buffers (slave).
interface main_ctrl_if;
    import main_ctrl_pkg::*;

    logic               in_full;
    logic [STAGE_N-1:0] stage_done;
    logic [STAGE_N-1:0] stage_run;
    logic               in_consume;
    logic               out_valid;
    logic               out_taken;

    modport master (
        input  in_full, stage_done, out_taken,
        output stage_run, in_consume, out_valid
    );

    modport slave (
        output in_full, stage_done, out_taken,
        input  stage_run, in_consume, out_valid
    );
endinterface

// File: rtl/main_ctrl_edge_det.sv
// Per-bit rising-edge detector: rise is high in the cycle a bit goes 0->1.
module edge_det #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] level,
    output logic [W-1:0] rise
);

    logic [W-1:0] prev;

    // Register previous level; cleared on reset so a held-high input edges once
    always_ff @(posedge clk) begin
        if (rst) prev <= '0;
        else     prev <= level;
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/main_ctrl.sv
// Top-level training sequencer: latches the mode, walks the stage pipeline
// (EMB, MIX, COMP and, in TRAIN, BWD, UPD), guards each stage with a
// watchdog and hands the result to the output streamer.
module main_ctrl
    import main_ctrl_pkg::*;
#(
    parameter int WDT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set,
    input  logic                 run,
    input  logic                 next,
    input  logic [MODE_LEN-1:0]  mode,
    main_ctrl_if.master          bus,
    output logic                 finish,
    output logic                 error,
    output logic [STATE_LEN-1:0] state_main
);

    // Counter value one step before all-ones; the step onto all-ones trips it
    localparam logic [WDT_W-1:0] WDT_LAST = {{(WDT_W-1){1'b1}}, 1'b0};

    state_t              state;
    logic [MODE_LEN-1:0] mode_q;
    logic                pending;
    logic [WDT_W-1:0]    wdt;
    logic [STAGE_N-1:0]  stage_run_q;
    logic                in_consume_q;
    logic                out_valid_q;
    logic                finish_q;
    logic                error_q;
    logic [2:0]          edges;
    logic                set_edge, run_edge, next_edge;
    logic                cur_done;

    edge_det #(.W(3)) u_edge (
        .clk   (clk),
        .rst   (rst),
        .level ({next, run, set}),
        .rise  (edges)
    );

    assign set_edge  = edges[0];
    assign run_edge  = edges[1];
    assign next_edge = edges[2];

    // Select the done bit belonging to the stage currently running
    always_comb begin
        cur_done = 1'b0;
        case (state)
            M_EMB:   cur_done = bus.stage_done[ST_EMB];
            M_MIX:   cur_done = bus.stage_done[ST_MIX];
            M_COMP:  cur_done = bus.stage_done[ST_COMP];
            M_BWD:   cur_done = bus.stage_done[ST_BWD];
            M_UPD:   cur_done = bus.stage_done[ST_UPD];
            default: cur_done = 1'b0;
        endcase
    end

    // Sequencer FSM with registered pulse/level outputs and stage watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            mode_q       <= FORWARD;
            pending      <= 1'b0;
            wdt          <= '0;
            stage_run_q  <= '0;
            in_consume_q <= 1'b0;
            out_valid_q  <= 1'b0;
            finish_q     <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            stage_run_q  <= '0;
            in_consume_q <= 1'b0;
            if (bus.out_taken && out_valid_q) out_valid_q <= 1'b0;

            case (state)
                IDLE, READY, FINISH: begin
                    if (set_edge) begin
                        mode_q   <= mode;
                        finish_q <= 1'b0;
                        pending  <= 1'b0;
                        if (mode_legal(mode)) begin
                            state <= READY;
                        end else begin
                            state   <= ERROR;
                            error_q <= 1'b1;
                        end
                    end else if (state == READY) begin
                        // EMB also waits for the previous batch's output to drain
                        if ((pending || run_edge) && bus.in_full && !out_valid_q) begin
                            state                <= M_EMB;
                            stage_run_q[ST_EMB]  <= 1'b1;
                            in_consume_q         <= 1'b1;
                            pending              <= 1'b0;
                            wdt                  <= '0;
                        end else if (run_edge) begin
                            pending <= 1'b1;
                        end
                    end else if (state == FINISH && next_edge) begin
                        state    <= READY;
                        finish_q <= 1'b0;
                    end
                end

                M_EMB, M_MIX, M_COMP, M_BWD, M_UPD: begin
                    if (cur_done) begin
                        wdt <= '0;
                        case (state)
                            M_EMB: begin
                                state               <= M_MIX;
                                stage_run_q[ST_MIX] <= 1'b1;
                            end
                            M_MIX: begin
                                state                <= M_COMP;
                                stage_run_q[ST_COMP] <= 1'b1;
                            end
                            M_COMP: begin
                                if (mode_q == TRAIN) begin
                                    state               <= M_BWD;
                                    stage_run_q[ST_BWD] <= 1'b1;
                                end else begin
                                    state       <= FINISH;
                                    finish_q    <= 1'b1;
                                    out_valid_q <= 1'b1;
                                end
                            end
                            M_BWD: begin
                                state               <= M_UPD;
                                stage_run_q[ST_UPD] <= 1'b1;
                            end
                            default: begin
                                state       <= FINISH;
                                finish_q    <= 1'b1;
                                out_valid_q <= 1'b1;
                            end
                        endcase
                    end else if (wdt == WDT_LAST) begin
                        wdt     <= '1;
                        state   <= ERROR;
                        error_q <= 1'b1;
                    end else begin
                        wdt <= wdt + 1'b1;
                    end
                end

                default: begin
                    state <= ERROR;
                end
            endcase
        end
    end

    assign bus.stage_run  = stage_run_q;
    assign bus.in_consume = in_consume_q;
    assign bus.out_valid  = out_valid_q;
    assign finish         = finish_q;
    assign error          = error_q;
    assign state_main     = state;

endmodule

// File: tb/tb_main_ctrl.sv
// Directed bench for main_ctrl: reset, TRAIN and FORWARD batches, pending run,
// back-to-back batches with output stall, watchdog trip and mid-stage reset.
module tb_main_ctrl;

    localparam logic [3:0] S_IDLE = 4'd0, S_READY = 4'd1, S_EMB = 4'd2, S_MIX = 4'd3,
                           S_BWD = 4'd5, S_FINISH = 4'd7, S_ERROR = 4'd8;
    localparam logic [2:0] M_FWD = 3'b001, M_TRN = 3'b010;

    logic       clk = 1'b0;
    logic       rst, set, run, next;
    logic [2:0] mode;
    logic       finish, error;
    logic [3:0] state_main;

    main_ctrl_if bus ();

    main_ctrl #(.WDT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .set        (set),
        .run        (run),
        .next       (next),
        .mode       (mode),
        .bus        (bus),
        .finish     (finish),
        .error      (error),
        .state_main (state_main)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    logic [4:0] seq [8];
    int         nseq, consumes, onehot_bad, first_cyc;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives a batch: answers each stage_run with stage_done three cycles later
    // and records the observed stage_run sequence until finish or budget end.
    task automatic run_batch(input bit do_run, input int budget);
        int         cd;
        logic [4:0] pbit;
        cd = 0; pbit = '0;
        nseq = 0; consumes = 0; onehot_bad = 0; first_cyc = -1;
        if (do_run) run = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            tick;
            run = 1'b0;
            bus.stage_done = '0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) bus.stage_done = pbit;
            end
            if ($countones(bus.stage_run) > 1) onehot_bad++;
            if (bus.in_consume) begin consumes++; bus.in_full = 1'b0; end
            if (bus.stage_run != '0) begin
                if (nseq < 8) seq[nseq] = bus.stage_run;
                nseq++;
                if (first_cyc < 0) first_cyc = c;
                cd = 3;
                pbit = bus.stage_run;
            end
            if (finish) break;
        end
        bus.stage_done = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1; set = 0; run = 0; next = 0; mode = M_FWD;
        bus.in_full = 0; bus.stage_done = '0; bus.out_taken = 0;
        tick; tick;
        rst = 1'b0;
        tick;
        vectors++; if (state_main !== S_IDLE) begin miscompares++; $display("FAIL reset_state got=%0d want=%0d", state_main, S_IDLE); end
        vectors++; if ({bus.stage_run, bus.in_consume, bus.out_valid, finish, error} !== 9'b0) begin
            miscompares++; $display("FAIL reset_outputs got=%b want=%b", {bus.stage_run, bus.in_consume, bus.out_valid, finish, error}, 9'b0); end
        run = 1'b1; tick; run = 1'b0; tick;
        vectors++; if (state_main !== S_IDLE) begin miscompares++; $display("FAIL run_in_idle got=%0d want=%0d", state_main, S_IDLE); end
    endtask

    task automatic test_train;
        mode = M_TRN; set = 1'b1; tick; set = 1'b0;
        vectors++; if (state_main !== S_READY) begin miscompares++; $display("FAIL train_set got=%0d want=%0d", state_main, S_READY); end
        bus.in_full = 1'b1;
        run_batch(1'b1, 200);
        vectors++; if (nseq !== 5) begin miscompares++; $display("FAIL train_nstages got=%0d want=5", nseq); end
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (seq[i] !== 5'(1 << i)) begin miscompares++; $display("FAIL train_order[%0d] got=%0d want=%0d", i, seq[i], 1 << i); end
        end
        vectors++; if (consumes !== 1) begin miscompares++; $display("FAIL train_consume got=%0d want=1", consumes); end
        vectors++; if (onehot_bad !== 0) begin miscompares++; $display("FAIL train_onehot got=%0d want=0", onehot_bad); end
        vectors++; if ({finish, bus.out_valid, state_main} !== {2'b11, S_FINISH}) begin
            miscompares++; $display("FAIL train_finish got=%b want=%b", {finish, bus.out_valid, state_main}, {2'b11, S_FINISH}); end
    endtask

    task automatic test_forward;
        bus.out_taken = 1'b1; tick; bus.out_taken = 1'b0;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL drain_train got=%b want=0", bus.out_valid); end
        mode = M_FWD; set = 1'b1; tick; set = 1'b0;
        vectors++; if ({finish, state_main} !== {1'b0, S_READY}) begin
            miscompares++; $display("FAIL fwd_set got=%b want=%b", {finish, state_main}, {1'b0, S_READY}); end
        bus.in_full = 1'b1;
        run_batch(1'b1, 200);
        vectors++; if (nseq !== 3) begin miscompares++; $display("FAIL fwd_nstages got=%0d want=3", nseq); end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (seq[i] !== 5'(1 << i)) begin miscompares++; $display("FAIL fwd_order[%0d] got=%0d want=%0d", i, seq[i], 1 << i); end
        end
        vectors++; if (state_main !== S_FINISH || finish !== 1'b1) begin
            miscompares++; $display("FAIL fwd_finish got=%0d/%b want=%0d/1", state_main, finish, S_FINISH); end
        repeat (5) tick;
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL fwd_valid_hold got=%b want=1", bus.out_valid); end
        bus.out_taken = 1'b1; tick; bus.out_taken = 1'b0;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL fwd_taken got=%b want=0", bus.out_valid); end
        bus.out_taken = 1'b1; tick; bus.out_taken = 1'b0;
        vectors++; if ({bus.out_valid, state_main} !== {1'b0, S_FINISH}) begin
            miscompares++; $display("FAIL taken_idle got=%b want=%b", {bus.out_valid, state_main}, {1'b0, S_FINISH}); end
        // set and next together: set wins and latches TRAIN
        mode = M_TRN; set = 1'b1; next = 1'b1; tick; set = 1'b0; next = 1'b0;
        vectors++; if ({finish, state_main} !== {1'b0, S_READY}) begin
            miscompares++; $display("FAIL set_next_prio got=%b want=%b", {finish, state_main}, {1'b0, S_READY}); end
    endtask

    task automatic test_pending;
        int bad;
        bad = 0;
        bus.in_full = 1'b0;
        run = 1'b1; tick; run = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.stage_run !== 5'd0 || state_main !== S_READY) bad++;
            tick;
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL pending_wait got=%0d want=0", bad); end
        bus.in_full = 1'b1;
        run_batch(1'b0, 200);
        vectors++; if (first_cyc !== 1) begin miscompares++; $display("FAIL pending_start got=%0d want=1", first_cyc); end
        vectors++; if (nseq !== 5) begin miscompares++; $display("FAIL pending_mode_kept got=%0d want=5", nseq); end
    endtask

    task automatic test_back_to_back;
        int bad;
        bad = 0;
        next = 1'b1; tick; next = 1'b0;
        vectors++; if ({finish, bus.out_valid, state_main} !== {2'b01, S_READY}) begin
            miscompares++; $display("FAIL b2b_next got=%b want=%b", {finish, bus.out_valid, state_main}, {2'b01, S_READY}); end
        bus.in_full = 1'b1;
        run = 1'b1; tick; run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (bus.stage_run !== 5'd0 || state_main !== S_READY) bad++;
            tick;
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL b2b_stall got=%0d want=0", bad); end
        bus.out_taken = 1'b1; tick; bus.out_taken = 1'b0;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain got=%b want=0", bus.out_valid); end
        run_batch(1'b0, 200);
        vectors++; if (first_cyc !== 1 || nseq !== 5) begin
            miscompares++; $display("FAIL b2b_batch got=%0d/%0d want=1/5", first_cyc, nseq); end
    endtask

    task automatic test_watchdog;
        int k;
        bus.out_taken = 1'b1; tick; bus.out_taken = 1'b0;
        next = 1'b1; tick; next = 1'b0;
        bus.in_full = 1'b1;
        run = 1'b1; tick; run = 1'b0; bus.in_full = 1'b0;
        vectors++; if (state_main !== S_EMB) begin miscompares++; $display("FAIL wdt_emb got=%0d want=%0d", state_main, S_EMB); end
        bus.stage_done = 5'b00001; tick;
        vectors++; if ({bus.stage_run, state_main} !== {5'b00010, S_MIX}) begin
            miscompares++; $display("FAIL wdt_mix got=%b want=%b", {bus.stage_run, state_main}, {5'b00010, S_MIX}); end
        bus.stage_done = 5'b11101;
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            tick;
            if (state_main == S_ERROR) begin k = i; break; end
        end
        bus.stage_done = '0;
        vectors++; if (k !== 15) begin miscompares++; $display("FAIL wdt_cycles got=%0d want=15", k); end
        vectors++; if ({error, bus.stage_run} !== 6'b100000) begin
            miscompares++; $display("FAIL wdt_error got=%b want=%b", {error, bus.stage_run}, 6'b100000); end
        mode = M_FWD; set = 1'b1; tick; set = 1'b0; run = 1'b1; tick; run = 1'b0; next = 1'b1; tick; next = 1'b0;
        tick;
        vectors++; if ({error, state_main} !== {1'b1, S_ERROR}) begin
            miscompares++; $display("FAIL error_sticky got=%b want=%b", {error, state_main}, {1'b1, S_ERROR}); end
    endtask

    task automatic test_rst_mid;
        int bad;
        bad = 0;
        rst = 1'b1; tick; rst = 1'b0;
        vectors++; if ({error, state_main} !== {1'b0, S_IDLE}) begin
            miscompares++; $display("FAIL rst_exit_error got=%b want=%b", {error, state_main}, {1'b0, S_IDLE}); end
        mode = M_TRN; set = 1'b1; tick; set = 1'b0;
        bus.in_full = 1'b1; run = 1'b1; tick; run = 1'b0; bus.in_full = 1'b0;
        bus.stage_done = 5'b00001; tick;
        bus.stage_done = 5'b00010; tick;
        bus.stage_done = 5'b00100; tick;
        bus.stage_done = '0;
        vectors++; if ({bus.stage_run, state_main} !== {5'b01000, S_BWD}) begin
            miscompares++; $display("FAIL reach_bwd got=%b want=%b", {bus.stage_run, state_main}, {5'b01000, S_BWD}); end
        rst = 1'b1; tick; rst = 1'b0;
        vectors++; if ({bus.stage_run, bus.in_consume, bus.out_valid, finish, error, state_main} !== {9'b0, S_IDLE}) begin
            miscompares++; $display("FAIL rst_mid got=%b want=%b",
                {bus.stage_run, bus.in_consume, bus.out_valid, finish, error, state_main}, {9'b0, S_IDLE}); end
        bus.stage_done = 5'b01000;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (bus.stage_run !== 5'd0 || state_main !== S_IDLE) bad++;
        end
        bus.stage_done = '0;
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL rst_no_pulse got=%0d want=0", bad); end
        mode = 3'b111; set = 1'b1; tick; set = 1'b0;
        vectors++; if ({error, state_main} !== {1'b1, S_ERROR}) begin
            miscompares++; $display("FAIL illegal_mode got=%b want=%b", {error, state_main}, {1'b1, S_ERROR}); end
    endtask

    initial begin
        test_reset;
        test_train;
        test_forward;
        test_pending;
        test_back_to_back;
        test_watchdog;
        test_rst_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=done");
        $fatal(1, "timeout");
    end

endmodule
